// File: rtl/fwrisc_dbus_wb_initiator.sv
// Bridges the fwrisc data port (dvalid/dready) onto a Wishbone B4 classic initiator,
// with a bus watchdog that aborts silent transfers and records sticky error status.
module fwrisc_dbus_wb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dvalid,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwstb,
    input  logic        dwrite,
    output logic [31:0] drdata,
    output logic        dready,
    output logic [31:0] ADR,
    output logic [31:0] DAT_W,
    input  logic [31:0] DAT_R,
    output logic        CYC,
    output logic        STB,
    output logic [3:0]  SEL,
    output logic        WE,
    input  logic        ACK,
    input  logic        ERR,
    output logic        bus_err,
    output logic        bus_timeout,
    output logic [31:0] err_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_CYCLES);

    state_t      state;
    logic [15:0] timer;
    logic [31:0] req_addr;

    logic [16:0] timer_next;
    logic        time_up;
    logic        bus_fault;
    logic        bus_done;

    // The abort fires on the cycle the count would reach the limit, so the timer
    // saturates at TIMEOUT_CYCLES and CYC stays up for exactly that many cycles.
    always_comb begin
        timer_next = {1'b0, timer} + 17'd1;
        time_up    = (timer_next >= TIMEOUT_LIM);
        bus_fault  = ERR || (!ACK && time_up);
        bus_done   = ERR || ACK || time_up;
    end

    // NOTE: every register uses <= so all of them sample pre-edge values together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            req_addr    <= '0;
            CYC         <= 1'b0;
            STB         <= 1'b0;
            WE          <= 1'b0;
            SEL         <= '0;
            ADR         <= '0;
            DAT_W       <= '0;
            dready      <= 1'b0;
            drdata      <= '0;
            bus_err     <= 1'b0;
            bus_timeout <= 1'b0;
            err_addr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dready <= 1'b0;
                    if (dvalid) begin
                        req_addr <= daddr;
                        ADR      <= {daddr[31:2], 2'b00};
                        DAT_W    <= dwdata;
                        WE       <= dwrite;
                        SEL      <= dwrite ? dwstb : 4'hF;
                        CYC      <= 1'b1;
                        STB      <= 1'b1;
                        timer    <= '0;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    timer <= timer_next[15:0];
                    if (bus_done) begin
                        CYC    <= 1'b0;
                        STB    <= 1'b0;
                        WE     <= 1'b0;
                        dready <= 1'b1;
                        state  <= RESP;
                        if (bus_fault) begin
                            drdata  <= ERR_RDATA;
                            bus_err <= 1'b1;
                            if (!bus_err) begin
                                err_addr <= req_addr;
                            end
                            if (!ERR) begin
                                bus_timeout <= 1'b1;
                            end
                        end else begin
                            drdata <= WE ? 32'h0000_0000 : DAT_R;
                        end
                    end
                end
                RESP: begin
                    // dvalid is still high here from the finished request; ignore it.
                    dready <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fwrisc_dbus_wb_initiator.sv
// Self-checking bench for fwrisc_dbus_wb_initiator: directed vector table, hand-written
// corner sequences, and randomized transfers scored against a transaction-level model.
module tb_fwrisc_dbus_wb_initiator;

    localparam int          TO      = 8;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;
    localparam int          R_ACK   = 0;
    localparam int          R_ERR   = 1;
    localparam int          R_NONE  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dvalid = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dwdata = '0;
    logic [3:0]  dwstb = '0;
    logic        dwrite = 1'b0;
    logic [31:0] drdata;
    logic        dready;
    logic [31:0] ADR;
    logic [31:0] DAT_W;
    logic [31:0] DAT_R = '0;
    logic        CYC;
    logic        STB;
    logic [3:0]  SEL;
    logic        WE;
    logic        ACK = 1'b0;
    logic        ERR = 1'b0;
    logic        bus_err;
    logic        bus_timeout;
    logic [31:0] err_addr;

    int n_cmp = 0;
    int n_bad = 0;

    fwrisc_dbus_wb_initiator #(
        .TIMEOUT_CYCLES(TO),
        .ERR_RDATA     (ERR_VAL)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dvalid     (dvalid),
        .daddr      (daddr),
        .dwdata     (dwdata),
        .dwstb      (dwstb),
        .dwrite     (dwrite),
        .drdata     (drdata),
        .dready     (dready),
        .ADR        (ADR),
        .DAT_W      (DAT_W),
        .DAT_R      (DAT_R),
        .CYC        (CYC),
        .STB        (STB),
        .SEL        (SEL),
        .WE         (WE),
        .ACK        (ACK),
        .ERR        (ERR),
        .bus_err    (bus_err),
        .bus_timeout(bus_timeout),
        .err_addr   (err_addr)
    );

    always #5 clock = ~clock;

    // Counts Wishbone cycle starts and dready pulses, sampled mid-cycle.
    int   cyc_starts = 0;
    int   rdy_pulses = 0;
    logic cyc_d = 1'b0;
    logic rdy_d = 1'b0;
    always @(negedge clock) begin
        if (CYC && !cyc_d) cyc_starts <= cyc_starts + 1;
        if (dready && !rdy_d) rdy_pulses <= rdy_pulses + 1;
        cyc_d <= CYC;
        rdy_d <= dready;
    end

    // Transaction-level model: sticky flags from the history of faulting transfers.
    logic [31:0] fault_q[$];
    bit          m_to;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  stb;
        logic        write;
        int          waits;
        int          resp;
        logic [31:0] rdata;
        logic [31:0] exp_drdata;
        logic        exp_err;
        logic        exp_to;
        logic [31:0] exp_eaddr;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Runs one core request against a scripted target and checks bus and core sides.
    task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] stb,
                           input logic write, input int waits, input int resp, input logic [31:0] rdata,
                           input logic [31:0] exp_drdata, input logic exp_err, input logic exp_to,
                           input logic [31:0] exp_eaddr);
        bit   timed_out;
        int   exp_cycles;
        int   c;
        bit   done;
        timed_out  = !(resp != R_NONE && waits < TO);
        exp_cycles = timed_out ? TO : waits + 1;

        check("idle_cyc", CYC, 1'b0);
        dvalid = 1'b1;
        daddr  = addr;
        dwdata = wdata;
        dwstb  = stb;
        dwrite = write;
        tick();
        check("issue_cyc", CYC, 1'b1);

        c    = 0;
        done = 0;
        while (!done && c <= 40) begin
            check("bus_stb", STB, 1'b1);
            check("bus_adr", ADR, {addr[31:2], 2'b00});
            check("bus_sel", SEL, write ? stb : 4'hF);
            check("bus_we",  WE, write);
            if (write) check("bus_datw", DAT_W, wdata);
            if (resp != R_NONE && c == waits) begin
                ACK   = (resp == R_ACK);
                ERR   = (resp == R_ERR);
                DAT_R = rdata;
            end else begin
                ACK   = 1'b0;
                ERR   = 1'b0;
                DAT_R = $urandom;
            end
            daddr  = $urandom;
            dwdata = $urandom;
            tick();
            c++;
            if (!CYC) done = 1;
        end
        ACK = 1'b0;
        ERR = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bus_cycle_bound: CYC still high after %0d cycles, required drop after %0d", c, exp_cycles);
            dvalid = 1'b0;
            return;
        end

        check("bus_cycles",  c, exp_cycles);
        check("rsp_dready",  dready, 1'b1);
        check("rsp_drdata",  drdata, exp_drdata);
        check("rsp_stb",     STB, 1'b0);
        check("rsp_we",      WE, 1'b0);
        check("rsp_bus_err", bus_err, exp_err);
        check("rsp_timeout", bus_timeout, exp_to);
        check("rsp_erraddr", err_addr, exp_eaddr);

        // Core still holds dvalid during dready; a late ACK follows any abort.
        ACK = timed_out;
        tick();
        ACK = 1'b0;
        check("post_dready", dready, 1'b0);
        check("post_cyc",    CYC, 1'b0);
        dvalid = 1'b0;
    endtask

    task automatic model_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] stb,
                              input logic write, input int waits, input int resp, input logic [31:0] rdata);
        bit          acked;
        logic [31:0] exp_d;
        acked = (resp == R_ACK) && (waits < TO);
        if (acked) begin
            exp_d = write ? 32'h0 : rdata;
        end else begin
            exp_d = ERR_VAL;
            fault_q.push_back(addr);
            if (!(resp == R_ERR && waits < TO)) m_to = 1;
        end
        do_xfer(addr, wdata, stb, write, waits, resp, rdata, exp_d,
                fault_q.size() > 0, m_to, fault_q.size() > 0 ? fault_q[0] : 32'h0);
    endtask

    initial begin
        int c0;
        int r0;

        vecs[0] = '{32'h8000_0010, 32'hCAFE_F00D, 4'b0011, 1'b1, 0, R_ACK,  32'h0,
                    32'h0,         1'b0, 1'b0, 32'h0};
        vecs[1] = '{32'h8000_0004, 32'h0,       4'b0000, 1'b0, 3, R_ACK,  32'h1234_5678,
                    32'h1234_5678, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{32'h9000_0000, 32'h0,       4'b0000, 1'b0, 1, R_ERR,  32'h5555_5555,
                    ERR_VAL,       1'b1, 1'b0, 32'h9000_0000};
        vecs[3] = '{32'h9000_0004, 32'h0,       4'b0000, 1'b0, 0, R_ERR,  32'h6666_6666,
                    ERR_VAL,       1'b1, 1'b0, 32'h9000_0000};
        vecs[4] = '{32'h8000_0008, 32'h0,       4'b0000, 1'b0, 0, R_NONE, 32'h0,
                    ERR_VAL,       1'b1, 1'b1, 32'h9000_0000};
        vecs[5] = '{32'h8000_000C, 32'h0,       4'b0000, 1'b0, 7, R_ACK,  32'hA5A5_5A5A,
                    32'hA5A5_5A5A, 1'b1, 1'b1, 32'h9000_0000};
        vecs[6] = '{32'h8000_0021, 32'h0BAD_CAFE, 4'b1000, 1'b1, 2, R_ACK, 32'hFFFF_FFFF,
                    32'h0,         1'b1, 1'b1, 32'h9000_0000};

        // Reset values.
        tick();
        tick();
        check("rst_cyc",     CYC, 1'b0);
        check("rst_stb",     STB, 1'b0);
        check("rst_we",      WE, 1'b0);
        check("rst_sel",     SEL, 4'h0);
        check("rst_adr",     ADR, 32'h0);
        check("rst_datw",    DAT_W, 32'h0);
        check("rst_dready",  dready, 1'b0);
        check("rst_drdata",  drdata, 32'h0);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_timeout", bus_timeout, 1'b0);
        check("rst_erraddr", err_addr, 32'h0);
        reset = 1'b0;
        tick();

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            do_xfer(vecs[i].addr, vecs[i].wdata, vecs[i].stb, vecs[i].write, vecs[i].waits,
                    vecs[i].resp, vecs[i].rdata, vecs[i].exp_drdata, vecs[i].exp_err,
                    vecs[i].exp_to, vecs[i].exp_eaddr);
            tick();
        end

        // Reset while a transfer is in BUS, with sticky flags already set.
        dvalid = 1'b1;
        daddr  = 32'h8000_0040;
        dwrite = 1'b0;
        tick();
        check("mid_pre_cyc", CYC, 1'b1);
        reset  = 1'b1;
        dvalid = 1'b0;
        tick();
        check("mid_cyc",     CYC, 1'b0);
        check("mid_stb",     STB, 1'b0);
        check("mid_dready",  dready, 1'b0);
        check("mid_bus_err", bus_err, 1'b0);
        check("mid_timeout", bus_timeout, 1'b0);
        check("mid_erraddr", err_addr, 32'h0);
        reset = 1'b0;
        fault_q.delete();
        m_to = 0;
        ACK  = 1'b1;
        tick();
        ACK = 1'b0;
        check("mid_idle_cyc",    CYC, 1'b0);
        check("mid_idle_dready", dready, 1'b0);
        model_xfer(32'h8000_0044, 32'h0, 4'h0, 1'b0, 0, R_ACK, 32'h0F0F_0F0F);
        tick();

        // Back-to-back reads: dvalid re-raised the cycle after each dready.
        c0 = cyc_starts;
        r0 = rdy_pulses;
        for (int i = 0; i < 4; i++) begin
            model_xfer(32'h8000_0100 + 32'(i * 4), 32'h0, 4'h0, 1'b0, i % 3, R_ACK, 32'h1000_0000 + 32'(i));
        end
        tick();
        tick();
        check("b2b_wb_cycles",  cyc_starts - c0, 4);
        check("b2b_dready_cnt", rdy_pulses - r0, 4);

        // Randomized transfers scored by the model.
        for (int i = 0; i < 40; i++) begin
            int          sel;
            int          resp;
            sel  = $urandom_range(0, 9);
            resp = (sel < 7) ? R_ACK : (sel < 9) ? R_ERR : R_NONE;
            model_xfer($urandom, $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, 9), resp, $urandom);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
